lycan_usb_rx_router: RTL and testbench

// Host->peripheral packet router. Takes 32-bit packets from the USB RX FIFO.

---
 rtl/lycan_usb_rx_router_pkg.sv | 17 +
 rtl/lycan_usb_rx_router_if.sv | 33 +++
 rtl/lycan_pkt_fifo2.sv | 57 +++++
 rtl/lycan_usb_rx_router.sv | 107 ++++++++++
 tb/tb_lycan_usb_rx_router.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lycan_usb_rx_router_pkg.sv
// Shared types and sizes for the host->peripheral packet router.
// Packet layout: [31:29] addr, [28] cfg, [27:0] payload.
package lycan_usb_rx_router_pkg;

  localparam int num_peripherals      = 8;
  localparam int usb_packet_width     = 32;
  localparam int periph_address_width = $clog2(num_peripherals);
  localparam int drop_cnt_width       = 16;
  localparam int rx_fifo_depth        = 2;

  typedef struct packed {
    logic [periph_address_width-1:0]                    addr;
    logic                                               cfg;
    logic [usb_packet_width-periph_address_width-2:0]   payload;
  } lycan_pkt_t;

endpackage

// File: rtl/lycan_usb_rx_router_if.sv
// Router data-path bundle: USB RX input handshake and per-slot outputs.
// slave = router side, master = FIFO/peripheral side.
interface lycan_usb_rx_router_if #(
  parameter int NUM_PERIPHS = 8,
  parameter int PKT_WIDTH   = 32
);

  logic [PKT_WIDTH-1:0]             usb_rx_data;
  logic                             usb_rx_valid;
  logic                             usb_rx_ready;
  logic [NUM_PERIPHS*PKT_WIDTH-1:0] periph_data;
  logic [NUM_PERIPHS-1:0]           periph_valid;
  logic [NUM_PERIPHS-1:0]           periph_ready;

  modport slave (
    input  usb_rx_data,
    input  usb_rx_valid,
    output usb_rx_ready,
    output periph_data,
    output periph_valid,
    input  periph_ready
  );

  modport master (
    output usb_rx_data,
    output usb_rx_valid,
    input  usb_rx_ready,
    input  periph_data,
    input  periph_valid,
    output periph_ready
  );

endinterface

// File: rtl/lycan_pkt_fifo2.sv
// Two-entry valid/ready packet FIFO for one peripheral slot.
// Ports: in_data/in_valid push, out_* pop handshake, full, count.
module lycan_pkt_fifo2
  import lycan_usb_rx_router_pkg::*;
#(
  parameter int W = usb_packet_width
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] m0;
  logic [W-1:0] m1;
  logic [1:0]   cnt;
  logic         wr;
  logic         rd;

  // full is judged on the pre-pop count, so a
  // full slot refuses a push even while popping
  assign full      = (cnt == 2'(rx_fifo_depth));
  assign wr        = in_valid && !full;
  assign out_valid = (cnt != 2'd0);
  assign rd        = out_valid && out_ready;
  assign out_data  = m0;
  assign count     = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0  <= '0;
      m1  <= '0;
      cnt <= '0;
    end else begin
      unique case (1'b1)
        wr && !rd: begin
          if (cnt == 2'd0) m0 <= in_data;
          else             m1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        rd && !wr: begin
          m0  <= m1;
          cnt <= cnt - 2'd1;
        end
        // only reachable with one entry held
        wr && rd: m0 <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lycan_usb_rx_router.sv
// Host->peripheral router: input register, addr decode, slot FIFOs,
// drop counter, busy. Ports: clk, rst, bus, periph_enable, drop_clr/count, busy.
module lycan_usb_rx_router
  import lycan_usb_rx_router_pkg::*;
#(
  parameter int NUM_PERIPHS = num_peripherals,
  parameter int PKT_WIDTH   = usb_packet_width,
  parameter int ADDR_WIDTH  = $clog2(NUM_PERIPHS),
  parameter int CNT_WIDTH   = drop_cnt_width
) (
  input  logic                   clk,
  input  logic                   rst,
  lycan_usb_rx_router_if.slave   bus,
  input  logic [NUM_PERIPHS-1:0] periph_enable,
  input  logic                   drop_clr,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic                   busy
);

  logic [PKT_WIDTH-1:0]   in_q;
  logic                   in_vld;
  logic [ADDR_WIDTH-1:0]  in_addr;
  logic [NUM_PERIPHS-1:0] hit;
  logic [NUM_PERIPHS-1:0] full;
  logic [NUM_PERIPHS-1:0] push;
  logic [NUM_PERIPHS-1:0] nonempty;
  logic [NUM_PERIPHS-1:0] slot_vld;
  logic [PKT_WIDTH-1:0]   slot_data [NUM_PERIPHS];
  logic [1:0]             slot_cnt  [NUM_PERIPHS];
  logic                   tgt_en;
  logic                   tgt_full;
  logic                   drain;
  logic                   drop;
  logic                   accept;

  assign in_addr = in_q[PKT_WIDTH-1 -: ADDR_WIDTH];

  // An address with no matching slot never hits,
  // so it reads as disabled and gets dropped
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PERIPHS; i++) begin
      hit[i] = in_vld && (in_addr == ADDR_WIDTH'(i));
    end
  end

  assign tgt_en   = |(hit & periph_enable);
  assign tgt_full = |(hit & full);
  assign drain    = in_vld && (!tgt_en || !tgt_full);
  assign drop     = drain && !tgt_en;
  assign push     = {NUM_PERIPHS{drain}} & hit & periph_enable;

  assign bus.usb_rx_ready = !rst && (!in_vld || drain);
  assign accept = bus.usb_rx_valid && bus.usb_rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q   <= '0;
      in_vld <= 1'b0;
    end else if (accept) begin
      in_q   <= bus.usb_rx_data;
      in_vld <= 1'b1;
    end else if (drain) begin
      in_vld <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PERIPHS; g++) begin : g_slot
    lycan_pkt_fifo2 #(
      .W (PKT_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_q),
      .in_valid  (push[g]),
      .out_data  (slot_data[g]),
      .out_valid (slot_vld[g]),
      .out_ready (bus.periph_ready[g]),
      .full      (full[g]),
      .count     (slot_cnt[g])
    );
    assign nonempty[g] = (slot_cnt[g] != 2'd0);
  end

  always_comb begin
    bus.periph_data = '0;
    for (int i = 0; i < NUM_PERIPHS; i++) begin
      bus.periph_data[i*PKT_WIDTH +: PKT_WIDTH] = slot_data[i];
    end
  end

  assign bus.periph_valid = slot_vld;

  // clear wins; a drop in the clearing cycle still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_clr) begin
      drop_count <= drop ? CNT_WIDTH'(1) : '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

  assign busy = in_vld || (|nonempty);

endmodule

// File: tb/tb_lycan_usb_rx_router.sv
// Self-checking bench for lycan_usb_rx_router: routing table,
// backpressure, drops, saturation, HOL, reset and random scoreboard.
module tb_lycan_usb_rx_router;
  import lycan_usb_rx_router_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en;
  logic        clr;
  logic [15:0] drop_count;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  lycan_usb_rx_router_if #(.NUM_PERIPHS(8), .PKT_WIDTH(32)) bus ();

  lycan_usb_rx_router dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .periph_enable (en),
    .drop_clr      (clr),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pkt;
    logic [7:0]  en;
    logic [7:0]  exp_vld;
    logic        exp_drop;
  } vec_t;

  vec_t vecs [8];

  // reference model state
  logic [31:0] q [8][$];
  bit          m_has;
  logic [31:0] m_pkt;
  int          m_drop;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slot(input int i);
    return bus.periph_data[i*32 +: 32];
  endfunction

  task automatic send(input logic [31:0] p);
    int n;
    n = 0;
    bus.usb_rx_data  = p;
    bus.usb_rx_valid = 1'b1;
    #1;
    while (!bus.usb_rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
    tick();
    bus.usb_rx_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) q[i].delete();
    m_has  = 0;
    m_pkt  = '0;
    m_drop = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 64'(bus.usb_rx_ready), 64'd0);
    chk({tag, "_pvalid"}, 64'(bus.periph_valid), 64'd0);
    chk({tag, "_pdata"}, 64'(|bus.periph_data), 64'd0);
    chk({tag, "_drop"}, 64'(drop_count), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] got [$];
    logic [31:0] exp_seq [3];
    logic [15:0] d0;
    int          a;
    int          n;
    bit          hold;
    bit          v;
    bit          rdy;
    bit          drn;
    bit          ok;
    logic [31:0] dat;
    logic [7:0]  pr;
    logic [7:0]  mask;

    vecs[0] = '{32'h2000_00AA, 8'hFF, 8'h02, 1'b0};
    vecs[1] = '{32'h0000_0001, 8'hFF, 8'h01, 1'b0};
    vecs[2] = '{32'h5ABC_DEF0, 8'hFF, 8'h04, 1'b0};
    vecs[3] = '{32'hE000_0007, 8'hFF, 8'h80, 1'b0};
    vecs[4] = '{32'hF000_0000, 8'hFF, 8'h80, 1'b0};
    vecs[5] = '{32'h6000_0055, 8'hF7, 8'h00, 1'b1};
    vecs[6] = '{32'h8000_0000, 8'hEF, 8'h00, 1'b1};
    vecs[7] = '{32'hA000_1234, 8'h20, 8'h20, 1'b0};

    rst = 1'b1;
    en  = 8'hFF;
    clr = 1'b0;
    bus.usb_rx_data  = '0;
    bus.usb_rx_valid = 1'b0;
    bus.periph_ready = '0;
    #3;
    reset_checks("rst_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(bus.usb_rx_ready), 64'd1);

    // routing table, 2-cycle latency
    foreach (vecs[k]) begin
      en = vecs[k].en;
      d0 = drop_count;
      send(vecs[k].pkt);
      chk("route_lat1", 64'(bus.periph_valid), 64'd0);
      tick();
      chk("route_valid", 64'(bus.periph_valid), 64'(vecs[k].exp_vld));
      a = int'(vecs[k].pkt[31:29]);
      if (vecs[k].exp_vld != 8'h00)
        chk("route_data", 64'(slot(a)), 64'(vecs[k].pkt));
      chk("route_drop", 64'(drop_count),
          64'(d0 + 16'(vecs[k].exp_drop)));
      chk("route_busy", 64'(busy), 64'(vecs[k].exp_vld != 8'h00));
      bus.periph_ready = 8'hFF;
      tick();
      bus.periph_ready = 8'h00;
      chk("route_flush", 64'(bus.periph_valid), 64'd0);
    end

    // backpressure on slot 5
    en = 8'hFF;
    exp_seq[0] = 32'hA000_0001;
    exp_seq[1] = 32'hA000_0002;
    exp_seq[2] = 32'hA000_0003;
    for (int i = 0; i < 3; i++) send(exp_seq[i]);
    #1;
    chk("bp_ready", 64'(bus.usb_rx_ready), 64'd0);
    chk("bp_valid", 64'(bus.periph_valid), 64'h20);
    chk("bp_head", 64'(slot(5)), 64'(exp_seq[0]));
    chk("bp_busy", 64'(busy), 64'd1);
    bus.periph_ready[5] = 1'b1;
    n = 0;
    while (got.size() < 3 && n < 20) begin
      if (bus.periph_valid[5]) got.push_back(slot(5));
      tick();
      n++;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < got.size() && i < 3; i++)
      chk("bp_order", 64'(got[i]), 64'(exp_seq[i]));
    bus.periph_ready = '0;
    chk("bp_idle", 64'(busy), 64'd0);

    // drops to disabled slot 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    en  = 8'hFE;
    for (int i = 0; i < 4; i++) send(32'h0000_0100 + 32'(i));
    tick();
    chk("drop_cnt4", 64'(drop_count), 64'd4);
    chk("drop_none", 64'(bus.periph_valid), 64'd0);
    send(32'h0000_0200);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("drop_clr_same", 64'(drop_count), 64'd1);

    // saturation by a long drop run
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.usb_rx_data  = 32'h0000_0000;
    bus.usb_rx_valid = 1'b1;
    for (int i = 0; i < 16'hFFFE; i++) tick();
    bus.usb_rx_valid = 1'b0;
    tick();
    chk("sat_pre", 64'(drop_count), 64'hFFFE);
    bus.usb_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.usb_rx_valid = 1'b0;
    tick();
    chk("sat_max", 64'(drop_count), 64'hFFFF);

    // HOL block on slot 2, then disable it
    clr = 1'b1;
    tick();
    clr = 1'b0;
    en = 8'hFF;
    send(32'h4000_0001);
    send(32'h4000_0002);
    send(32'h4000_0003);
    bus.usb_rx_data  = 32'h6000_0009;
    bus.usb_rx_valid = 1'b1;
    #1;
    chk("hol_stall", 64'(bus.usb_rx_ready), 64'd0);
    tick();
    chk("hol_still", 64'(bus.usb_rx_ready), 64'd0);
    en[2] = 1'b0;
    #1;
    chk("hol_unblock", 64'(bus.usb_rx_ready), 64'd1);
    tick();
    bus.usb_rx_valid = 1'b0;
    chk("hol_drop", 64'(drop_count), 64'd1);
    tick();
    chk("hol_valid", 64'(bus.periph_valid), 64'h0C);
    chk("hol_s3", 64'(slot(3)), 64'h6000_0009);
    chk("hol_h0", 64'(slot(2)), 64'h4000_0001);
    bus.periph_ready = 8'hFF;
    tick();
    chk("hol_h1", 64'(slot(2)), 64'h4000_0002);
    chk("hol_v1", 64'(bus.periph_valid), 64'h04);
    tick();
    chk("hol_empty", 64'(bus.periph_valid), 64'h00);
    bus.periph_ready = '0;
    en = 8'hFF;

    // mid-stream reset
    send(32'h2000_0001);
    send(32'h2000_0002);
    send(32'h2000_0003);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(bus.usb_rx_ready), 64'd1);
    tick();
    chk("rst_mid_nodeliver", 64'(bus.periph_valid), 64'd0);

    // random traffic against the queue model
    model_reset();
    hold = 0;
    v    = 0;
    dat  = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        v   = ($urandom_range(3) != 0);
        dat = $urandom;
      end
      en  = ($urandom_range(7) == 0) ? 8'($urandom) : 8'hFF;
      pr  = 8'($urandom);
      clr = ($urandom_range(63) == 0);
      bus.usb_rx_valid = v;
      bus.usb_rx_data  = dat;
      bus.periph_ready = pr;
      #1;
      a   = int'(m_pkt[31:29]);
      ok  = m_has && (a < 8) && en[a];
      drn = m_has && (!ok || q[a].size() < 2);
      rdy = !m_has || drn;
      chk("rnd_ready", 64'(bus.usb_rx_ready), 64'(rdy));
      for (int i = 0; i < 8; i++)
        if (pr[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (drn && ok) q[a].push_back(m_pkt);
      if (clr) m_drop = (drn && !ok) ? 1 : 0;
      else if (drn && !ok && m_drop < 65535) m_drop++;
      if (drn) m_has = 0;
      if (v && rdy) begin
        m_has = 1;
        m_pkt = dat;
      end
      hold = v && !rdy;
      tick();
      mask = '0;
      for (int i = 0; i < 8; i++) mask[i] = (q[i].size() > 0);
      chk("rnd_pvalid", 64'(bus.periph_valid), 64'(mask));
      for (int i = 0; i < 8; i++)
        if (q[i].size() > 0) chk("rnd_pdata", 64'(slot(i)), 64'(q[i][0]));
      chk("rnd_drop", 64'(drop_count), 64'(m_drop));
      chk("rnd_busy", 64'(busy), 64'(m_has || (mask != 8'h00)));
    end
    clr = 1'b0;
    bus.usb_rx_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
